// File: rtl/calc_pkg.sv
// Shared opcodes, sequencer state encoding and divide-by-zero helper for the calc sequencer slice.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    function automatic logic is_div_zero(input logic [1:0] op, input logic b_is_zero);
        return (op == OP_DIV) && b_is_zero;
    endfunction

endpackage

// File: rtl/calc_rr_sequencer_arb.sv
// rr_arbiter2: combinational 2-way round-robin grant; a lone requester always wins, ties go to !last_grant.
module rr_arbiter2 (
    input  logic [1:0] valids,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_id,
    output logic       grant_any
);

    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        case (valids)
            2'b01: begin
                grant    = 2'b01;
                grant_id = 1'b0;
            end
            2'b10: begin
                grant    = 2'b10;
                grant_id = 1'b1;
            end
            2'b11: begin
                grant_id = ~last_grant;
                grant    = last_grant ? 2'b01 : 2'b10;
            end
            default: begin
                grant    = 2'b00;
                grant_id = 1'b0;
            end
        endcase
    end

    assign grant_any = |valids;

endmodule

// File: rtl/calculator.sv
// Combinational add/sub/mul/div datapath shared by the sequencer; zero latency, no flow control.
module calculator
    import calc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    input  logic [1:0]     op,
    output logic [2*N-1:0] Result,
    output logic           C_out
);

    logic [N:0] s;

    always_comb begin
        Result = '0;
        C_out  = 1'b0;
        s      = '0;
        case (op)
            OP_ADD: begin
                s      = {1'b0, A} + {1'b0, B};
                Result = {{(N-1){1'b0}}, s};
                C_out  = s[N];
            end
            OP_SUB: begin
                // C_out is the borrow; the result keeps the N-bit two's complement difference
                s      = {1'b0, A} - {1'b0, B};
                Result = {{N{1'b0}}, s[N-1:0]};
                C_out  = s[N];
            end
            OP_MUL: begin
                Result = {{N{1'b0}}, A} * {{N{1'b0}}, B};
            end
            default: begin
                if (B != '0) begin
                    Result = {{N{1'b0}}, A / B};
                end
            end
        endcase
    end

endmodule

// File: rtl/calc_rr_sequencer.sv
// calc_rr_sequencer: round-robin shares one calculator between two requesters; rsp_valid 2 clocks after accept, held while rsp_ready=0.
// Optional macro CALC_SEQ_STATS_EN adds 16-bit stat_ops / stat_errs response-handshake counters.
module calc_rr_sequencer
    import calc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    input  logic [1:0]     req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    input  logic [1:0]     req1_op,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*N-1:0] rsp_result,
    output logic           rsp_cout,
    output logic           rsp_err,
    output logic [N-1:0]   calc_a,
    output logic [N-1:0]   calc_b,
    output logic [1:0]     calc_op,
    input  logic [2*N-1:0] calc_result,
    input  logic           calc_cout
`ifdef CALC_SEQ_STATS_EN
    ,
    output logic [15:0]    stat_ops,
    output logic [15:0]    stat_errs
`endif
);

    state_t     state;
    logic       last_grant;
    logic [1:0] grant;
    logic       grant_id;
    logic       grant_any;
    logic       in_idle;
    logic       div_zero;

    rr_arbiter2 u_arb (
        .valids     ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_id   (grant_id),
        .grant_any  (grant_any)
    );

    // Readies are masked by rst so every output reads 0 while reset is held
    assign in_idle    = (state == ST_IDLE) && !rst;
    assign req0_ready = in_idle && grant[0];
    assign req1_ready = in_idle && grant[1];

    assign div_zero = is_div_zero(calc_op, calc_b == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            calc_a     <= '0;
            calc_b     <= '0;
            calc_op    <= OP_ADD;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        calc_a     <= grant_id ? req1_a  : req0_a;
                        calc_b     <= grant_id ? req1_b  : req0_b;
                        calc_op    <= grant_id ? req1_op : req0_op;
                        rsp_id     <= grant_id;
                        last_grant <= grant_id;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Divide-by-zero never trusts the datapath output
                    if (div_zero) begin
                        rsp_result <= '1;
                        rsp_cout   <= 1'b0;
                        rsp_err    <= 1'b1;
                    end else begin
                        rsp_result <= calc_result;
                        rsp_cout   <= calc_cout;
                        rsp_err    <= 1'b0;
                    end
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CALC_SEQ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops  <= 16'd0;
            stat_errs <= 16'd0;
        end else if (rsp_valid && rsp_ready) begin
            stat_ops <= stat_ops + 16'd1;
            if (rsp_err) begin
                stat_errs <= stat_errs + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_calc_rr_sequencer.sv
// Directed bench for calc_rr_sequencer driving a real calculator datapath.
module tb_calc_rr_sequencer;
    import calc_pkg::*;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [N-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic [1:0]     req0_op, req1_op;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_err;
    logic [2*N-1:0] rsp_result;
    logic [N-1:0]   calc_a, calc_b;
    logic [1:0]     calc_op;
    logic [2*N-1:0] calc_result;
    logic           calc_cout;
`ifdef CALC_SEQ_STATS_EN
    logic [15:0]    stat_ops, stat_errs;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    calc_rr_sequencer #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_cout    (rsp_cout),
        .rsp_err     (rsp_err),
        .calc_a      (calc_a),
        .calc_b      (calc_b),
        .calc_op     (calc_op),
        .calc_result (calc_result),
        .calc_cout   (calc_cout)
`ifdef CALC_SEQ_STATS_EN
        ,
        .stat_ops    (stat_ops),
        .stat_errs   (stat_errs)
`endif
    );

    calculator #(.N(N)) u_calc (
        .A      (calc_a),
        .B      (calc_b),
        .op     (calc_op),
        .Result (calc_result),
        .C_out  (calc_cout)
    );

    // Issues one request on a port, scrambles its operands after accept, and returns the response fields.
    task automatic do_op(input logic port, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [1:0] op, output logic id, output logic [2*N-1:0] res,
                         output logic cout, output logic err, output int lat,
                         output logic rdy_bad, output logic to);
        int n;
        to = 1'b0; rdy_bad = 1'b0; lat = 0; id = 1'b0; res = '0; cout = 1'b0; err = 1'b0;
        @(negedge clk);
        if (port) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        #1;
        n = 0;
        while (!(port ? req1_ready : req0_ready)) begin
            @(negedge clk); #1;
            n++;
            if (n > 20) begin
                to = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        if (port) begin
            req1_valid = 1'b0; req1_a = ~a; req1_b = ~b; req1_op = ~op;
        end else begin
            req0_valid = 1'b0; req0_a = ~a; req0_b = ~b; req0_op = ~op;
        end
        #1;
        lat = 1;
        while (!rsp_valid) begin
            if (req0_ready || req1_ready) rdy_bad = 1'b1;
            @(negedge clk); #1;
            lat++;
            if (lat > 20) begin
                to = 1'b1;
                return;
            end
        end
        if (req0_ready || req1_ready) rdy_bad = 1'b1;
        id = rsp_id; res = rsp_result; cout = rsp_cout; err = rsp_err;
    endtask

    task automatic test_reset();
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_result !== 16'd0) begin errors++; $display("FAIL reset_rsp_result got %0d exp 0", rsp_result); end
        checks++; if ({rsp_id, rsp_cout, rsp_err} !== 3'b000) begin errors++; $display("FAIL reset_rsp_flags got %b exp 000", {rsp_id, rsp_cout, rsp_err}); end
        checks++; if ({calc_a, calc_b, calc_op} !== 18'd0) begin errors++; $display("FAIL reset_calc got %h exp 0", {calc_a, calc_b, calc_op}); end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready_in_rst got %b exp 00", {req1_ready, req0_ready}); end
`ifdef CALC_SEQ_STATS_EN
        checks++; if ({stat_ops, stat_errs} !== 32'd0) begin errors++; $display("FAIL reset_stats got %h exp 0", {stat_ops, stat_errs}); end
`endif
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_arbitration();
        logic exp_id;
        int n;
        rsp_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd2; req0_op = OP_ADD;
        req1_valid = 1'b1; req1_a = 8'd7; req1_b = 8'd3; req1_op = OP_SUB;
        for (int i = 0; i < 4; i++) begin
            exp_id = i[0];
            #1;
            n = 0;
            while (!(req0_ready || req1_ready)) begin
                @(negedge clk); #1;
                n++;
                if (n > 10) begin
                    checks++; errors++; $display("FAIL arb_timeout op %0d got no ready exp ready", i);
                    req0_valid = 1'b0; req1_valid = 1'b0;
                    return;
                end
            end
            checks++; if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin errors++; $display("FAIL arb_grant op %0d got %b exp %b", i, {req1_ready, req0_ready}, exp_id ? 2'b10 : 2'b01); end
            @(negedge clk); #1;
            checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL arb_ready_issue got %b exp 00", {req1_ready, req0_ready}); end
            @(negedge clk); #1;
            checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL arb_ready_resp got %b exp 00", {req1_ready, req0_ready}); end
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id) begin errors++; $display("FAIL arb_rsp_id got v=%b id=%b exp v=1 id=%b", rsp_valid, rsp_id, exp_id); end
            checks++; if (rsp_result !== (exp_id ? 16'd4 : 16'd3)) begin errors++; $display("FAIL arb_rsp_result got %0d exp %0d", rsp_result, exp_id ? 4 : 3); end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_add();
        logic id, cout, err, rdy_bad, to;
        logic [2*N-1:0] res;
        int lat;
        rsp_ready = 1'b1;
        do_op(1'b0, 8'd200, 8'd100, OP_ADD, id, res, cout, err, lat, rdy_bad, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL add_timeout got %b exp 0", to); end
        checks++; if (lat != 2) begin errors++; $display("FAIL add_latency got %0d exp 2", lat); end
        checks++; if (id !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL add_id_err got id=%b err=%b exp 0 0", id, err); end
        checks++; if (res !== 16'd300 || cout !== 1'b1) begin errors++; $display("FAIL add_result got %0d c=%b exp 300 c=1", res, cout); end
        checks++; if (rdy_bad !== 1'b0) begin errors++; $display("FAIL add_ready_busy got %b exp 0", rdy_bad); end
    endtask

    task automatic test_sub_mul();
        logic id, cout, err, rdy_bad, to;
        logic [2*N-1:0] res;
        int lat;
        rsp_ready = 1'b1;
        do_op(1'b1, 8'd100, 8'd30, OP_SUB, id, res, cout, err, lat, rdy_bad, to);
        checks++; if (to !== 1'b0 || lat != 2) begin errors++; $display("FAIL sub_latency got to=%b lat=%0d exp to=0 lat=2", to, lat); end
        checks++; if (id !== 1'b1 || res !== 16'd70 || cout !== 1'b0) begin errors++; $display("FAIL sub_result got id=%b %0d c=%b exp id=1 70 c=0", id, res, cout); end
        do_op(1'b1, 8'd100, 8'd100, OP_MUL, id, res, cout, err, lat, rdy_bad, to);
        checks++; if (to !== 1'b0 || lat != 2) begin errors++; $display("FAIL mul_latency got to=%b lat=%0d exp to=0 lat=2", to, lat); end
        checks++; if (id !== 1'b1 || res !== 16'd10000 || err !== 1'b0) begin errors++; $display("FAIL mul_result got id=%b %0d err=%b exp id=1 10000 err=0", id, res, err); end
    endtask

    task automatic test_div();
        logic id, cout, err, rdy_bad, to;
        logic [2*N-1:0] res;
        int lat;
`ifdef CALC_SEQ_STATS_EN
        logic [15:0] ops0, errs0;
`endif
        rsp_ready = 1'b1;
        do_op(1'b1, 8'd100, 8'd9, OP_DIV, id, res, cout, err, lat, rdy_bad, to);
        checks++; if (to !== 1'b0 || lat != 2) begin errors++; $display("FAIL div_latency got to=%b lat=%0d exp to=0 lat=2", to, lat); end
        checks++; if (res !== 16'd11 || err !== 1'b0) begin errors++; $display("FAIL div_result got %0d err=%b exp 11 err=0", res, err); end
        @(negedge clk);
`ifdef CALC_SEQ_STATS_EN
        ops0 = stat_ops; errs0 = stat_errs;
`endif
        do_op(1'b1, 8'd50, 8'd0, OP_DIV, id, res, cout, err, lat, rdy_bad, to);
        checks++; if (to !== 1'b0 || lat != 2) begin errors++; $display("FAIL div0_latency got to=%b lat=%0d exp to=0 lat=2", to, lat); end
        checks++; if (res !== 16'hFFFF || err !== 1'b1 || cout !== 1'b0) begin errors++; $display("FAIL div0_result got %h err=%b c=%b exp ffff err=1 c=0", res, err, cout); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL div0_clear got v=%b err=%b exp 0 0", rsp_valid, rsp_err); end
`ifdef CALC_SEQ_STATS_EN
        checks++; if (stat_ops - ops0 !== 16'd1 || stat_errs - errs0 !== 16'd1) begin errors++; $display("FAIL stats_delta got ops+%0d errs+%0d exp 1 1", stat_ops - ops0, stat_errs - errs0); end
`endif
    endtask

    task automatic test_backpressure();
        logic id, cout, err, rdy_bad, to;
        logic [2*N-1:0] res;
        int lat;
        rsp_ready = 1'b0;
        do_op(1'b0, 8'd5, 8'd6, OP_MUL, id, res, cout, err, lat, rdy_bad, to);
        checks++; if (to !== 1'b0 || res !== 16'd30 || id !== 1'b0) begin errors++; $display("FAIL bp_first got to=%b %0d id=%b exp to=0 30 id=0", to, res, id); end
        req1_valid = 1'b1; req1_a = 8'd9; req1_b = 8'd1; req1_op = OP_ADD;
        repeat (5) begin
            @(negedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_result !== 16'd30 || rsp_id !== 1'b0) begin errors++; $display("FAIL bp_rsp_hold got v=%b %0d id=%b exp v=1 30 id=0", rsp_valid, rsp_result, rsp_id); end
            checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready got %b exp 00", {req1_ready, req0_ready}); end
            checks++; if (calc_a !== 8'd5 || calc_b !== 8'd6 || calc_op !== OP_MUL) begin errors++; $display("FAIL bp_calc got %0d %0d %b exp 5 6 10", calc_a, calc_b, calc_op); end
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin errors++; $display("FAIL bp_resume got v=%b rdy1=%b exp v=0 rdy1=1", rsp_valid, req1_ready); end
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 16'd10 || rsp_id !== 1'b1) begin errors++; $display("FAIL bp_second got v=%b %0d id=%b exp v=1 10 id=1", rsp_valid, rsp_result, rsp_id); end
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        int n;
        rsp_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd4; req0_op = OP_ADD;
        #1;
        n = 0;
        while (!req0_ready) begin
            @(negedge clk); #1;
            n++;
            if (n > 10) begin
                checks++; errors++; $display("FAIL midrst_timeout got no ready exp ready");
                req0_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++; if (calc_a !== 8'd3) begin errors++; $display("FAIL midrst_issue_calc got %0d exp 3", calc_a); end
        rst = 1'b1;
        #1;
        checks++; if ({calc_a, calc_b, calc_op} !== 18'd0) begin errors++; $display("FAIL midrst_calc got %h exp 0", {calc_a, calc_b, calc_op}); end
        checks++; if (rsp_valid !== 1'b0 || rsp_result !== 16'd0) begin errors++; $display("FAIL midrst_rsp got v=%b %0d exp 0 0", rsp_valid, rsp_result); end
        req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd4;
        req1_valid = 1'b1; req1_a = 8'd8; req1_b = 8'd8; req1_op = OP_ADD;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0 || {req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL midrst_held got v=%b rdy=%b exp 0 00", rsp_valid, {req1_ready, req0_ready}); end
`ifdef CALC_SEQ_STATS_EN
        checks++; if ({stat_ops, stat_errs} !== 32'd0) begin errors++; $display("FAIL midrst_stats got %h exp 0", {stat_ops, stat_errs}); end
`endif
        rst = 1'b0;
        #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL midrst_first_grant got %b exp 01", {req1_ready, req0_ready}); end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 16'd7) begin errors++; $display("FAIL midrst_rsp_after got v=%b id=%b %0d exp 1 0 7", rsp_valid, rsp_id, rsp_result); end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_arbitration();
        test_add();
        test_sub_mul();
        test_div();
        test_backpressure();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
